// File: rtl/jtag_tap_registers_pkg.sv
// Shared JTAG definitions: 16-state TAP encoding, instruction codes and DR selection.
// The TAP controller imports this package too, so state codes must stay stable.
package jtag_tap_registers_pkg;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET = 4'd0,
    RUN_TEST_IDLE    = 4'd1,
    SELECT_DR_SCAN   = 4'd2,
    CAPTURE_DR       = 4'd3,
    SHIFT_DR         = 4'd4,
    EXIT1_DR         = 4'd5,
    PAUSE_DR         = 4'd6,
    EXIT2_DR         = 4'd7,
    UPDATE_DR        = 4'd8,
    SELECT_IR_SCAN   = 4'd9,
    CAPTURE_IR       = 4'd10,
    SHIFT_IR         = 4'd11,
    EXIT1_IR         = 4'd12,
    PAUSE_IR         = 4'd13,
    EXIT2_IR         = 4'd14,
    UPDATE_IR        = 4'd15
  } tap_state_e;

  localparam int          IR_WIDTH   = 4;
  localparam logic [3:0]  IR_ABORT   = 4'b1000;
  localparam logic [3:0]  IR_USER    = 4'b1010;
  localparam logic [3:0]  IR_IDCODE  = 4'b1110;
  localparam logic [3:0]  IR_BYPASS  = 4'b1111;
  localparam logic [3:0]  IR_CAPTURE = 4'b0001;

  typedef enum logic [1:0] {
    DR_BYPASS,
    DR_IDCODE,
    DR_USER
  } dr_sel_e;

  // Unassigned codes, ABORT included, fall through to the bypass register.
  function automatic dr_sel_e decode_dr(input logic [IR_WIDTH-1:0] ir);
    case (ir)
      IR_IDCODE: return DR_IDCODE;
      IR_USER:   return DR_USER;
      default:   return DR_BYPASS;
    endcase
  endfunction

endpackage

// File: rtl/jtag_tap_registers_if.sv
// Signal bundle between the TAP controller side (master) and the TAP register block (slave).
interface jtag_tap_registers_if #(
  parameter int USER_WIDTH = 8
);
  import jtag_tap_registers_pkg::*;

  tap_state_e              tap_state;
  logic                    tdi;
  logic [USER_WIDTH-1:0]   user_status;
  logic                    tdo;
  logic                    tdo_en;
  logic [IR_WIDTH-1:0]     ir_value;
  logic [USER_WIDTH-1:0]   user_data;
  logic                    abort_pulse;

  modport master (
    output tap_state, tdi, user_status,
    input  tdo, tdo_en, ir_value, user_data, abort_pulse
  );

  modport slave (
    input  tap_state, tdi, user_status,
    output tdo, tdo_en, ir_value, user_data, abort_pulse
  );

endinterface

// File: rtl/jtag_shift_reg.sv
// Generic JTAG scan register: parallel capture, right shift with serial input at the MSB,
// otherwise hold. Serial output is the LSB.
module jtag_shift_reg #(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             tck,
  input  logic             trst_n,
  input  logic             capture_en,
  input  logic [WIDTH-1:0] capture_value,
  input  logic             shift_en,
  input  logic             si,
  output logic             so,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_d, data_q;

  always_comb begin
    // NOTE: default assignment first, so every path drives data_d and no latch is inferred.
    data_d = data_q;
    if (capture_en) begin
      data_d = capture_value;
    end else if (shift_en) begin
      // Concatenate then shift so the WIDTH == 1 case needs no special slice.
      data_d = WIDTH'({si, data_q} >> 1);
    end
  end

  always_ff @(posedge tck or negedge trst_n) begin
    // NOTE: non-blocking assignments keep all flops sampling pre-edge values in parallel.
    if (!trst_n) begin
      data_q <= RESET_VALUE;
    end else begin
      data_q <= data_d;
    end
  end

  assign so = data_q[0];
  assign q  = data_q;

endmodule

// File: rtl/jtag_tap_registers.sv
// JTAG TAP instruction and data registers (IR, IDCODE, BYPASS, USER) driven by an
// externally decoded TAP state; tdo is combinational so the captured LSB appears at once.
module jtag_tap_registers
  import jtag_tap_registers_pkg::*;
#(
  parameter logic [31:0] IDCODE_VALUE = 32'h000FAF01,
  parameter int          USER_WIDTH   = 8
) (
  input  logic                  tck,
  input  logic                  trst_n,
  jtag_tap_registers_if.slave   bus
);

  logic                  st_capture_ir, st_shift_ir, st_capture_dr, st_shift_dr;
  dr_sel_e               dr_sel;

  logic [IR_WIDTH-1:0]   ir_shift;
  logic                  ir_so;
  logic                  idcode_so;
  logic [31:0]           idcode_unused;
  logic [USER_WIDTH-1:0] user_shift;
  logic                  user_so;

  logic [IR_WIDTH-1:0]   ir_value_d, ir_value_q;
  logic [USER_WIDTH-1:0] user_data_d, user_data_q;
  logic                  abort_pulse_d, abort_pulse_q;
  logic                  bypass_d, bypass_q;
  logic                  tdo_raw;

  assign st_capture_ir = (bus.tap_state == CAPTURE_IR);
  assign st_shift_ir   = (bus.tap_state == SHIFT_IR);
  assign st_capture_dr = (bus.tap_state == CAPTURE_DR);
  assign st_shift_dr   = (bus.tap_state == SHIFT_DR);

  // Selection follows the committed instruction, not the IR shift contents.
  assign dr_sel = decode_dr(ir_value_q);

  jtag_shift_reg #(
    .WIDTH       (IR_WIDTH),
    .RESET_VALUE (IR_CAPTURE)
  ) u_ir_shift (
    .tck           (tck),
    .trst_n        (trst_n),
    .capture_en    (st_capture_ir),
    .capture_value (IR_CAPTURE),
    .shift_en      (st_shift_ir),
    .si            (bus.tdi),
    .so            (ir_so),
    .q             (ir_shift)
  );

  jtag_shift_reg #(
    .WIDTH       (32),
    .RESET_VALUE ('0)
  ) u_idcode_shift (
    .tck           (tck),
    .trst_n        (trst_n),
    .capture_en    (st_capture_dr && (dr_sel == DR_IDCODE)),
    .capture_value (IDCODE_VALUE),
    .shift_en      (st_shift_dr && (dr_sel == DR_IDCODE)),
    .si            (bus.tdi),
    .so            (idcode_so),
    .q             (idcode_unused)
  );

  jtag_shift_reg #(
    .WIDTH       (USER_WIDTH),
    .RESET_VALUE ('0)
  ) u_user_shift (
    .tck           (tck),
    .trst_n        (trst_n),
    .capture_en    (st_capture_dr && (dr_sel == DR_USER)),
    .capture_value (bus.user_status),
    .shift_en      (st_shift_dr && (dr_sel == DR_USER)),
    .si            (bus.tdi),
    .so            (user_so),
    .q             (user_shift)
  );

  always_comb begin
    ir_value_d    = ir_value_q;
    user_data_d   = user_data_q;
    abort_pulse_d = 1'b0;
    bypass_d      = bypass_q;
    case (bus.tap_state)
      TEST_LOGIC_RESET: ir_value_d = IR_IDCODE;
      UPDATE_IR: begin
        ir_value_d    = ir_shift;
        abort_pulse_d = (ir_shift == IR_ABORT);
      end
      UPDATE_DR: begin
        if (ir_value_q == IR_USER) user_data_d = user_shift;
      end
      CAPTURE_DR: begin
        if (dr_sel == DR_BYPASS) bypass_d = 1'b0;
      end
      SHIFT_DR: begin
        if (dr_sel == DR_BYPASS) bypass_d = bus.tdi;
      end
      default: ;
    endcase
  end

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      ir_value_q    <= IR_IDCODE;
      user_data_q   <= '0;
      abort_pulse_q <= 1'b0;
      bypass_q      <= 1'b0;
    end else begin
      ir_value_q    <= ir_value_d;
      user_data_q   <= user_data_d;
      abort_pulse_q <= abort_pulse_d;
      bypass_q      <= bypass_d;
    end
  end

  always_comb begin
    tdo_raw = 1'b0;
    if (st_shift_ir) begin
      tdo_raw = ir_so;
    end else if (st_shift_dr) begin
      case (dr_sel)
        DR_IDCODE: tdo_raw = idcode_so;
        DR_USER:   tdo_raw = user_so;
        default:   tdo_raw = bypass_q;
      endcase
    end
  end

  // Reset gates the serial port so a stuck tap_state cannot drive the chain.
  assign bus.tdo         = trst_n & tdo_raw;
  assign bus.tdo_en      = trst_n & (st_shift_ir | st_shift_dr);
  assign bus.ir_value    = ir_value_q;
  assign bus.user_data   = user_data_q;
  assign bus.abort_pulse = abort_pulse_q;

endmodule

// File: tb/tb_jtag_tap_registers.sv
// Scoreboard bench for jtag_tap_registers: stimulus pushes expectations, a negedge monitor compares.
`timescale 1ns/1ps
module tb_jtag_tap_registers;
  import jtag_tap_registers_pkg::*;

  localparam int          UW     = 8;
  localparam logic [31:0] IDCODE = 32'h000FAF01;

  logic tck = 1'b0;
  logic trst_n;

  jtag_tap_registers_if #(.USER_WIDTH(UW)) bus ();

  jtag_tap_registers #(
    .IDCODE_VALUE (IDCODE),
    .USER_WIDTH   (UW)
  ) dut (
    .tck    (tck),
    .trst_n (trst_n),
    .bus    (bus)
  );

  always #5 tck = ~tck;

  typedef enum {K_TDO, K_TDO_EN, K_IR, K_USER, K_ABORT} kind_e;
  typedef struct {
    int          cyc;
    kind_e       kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  exp_t tdo_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   passes = 0;

  always @(posedge tck) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [31:0] observe(input kind_e k);
    case (k)
      K_TDO:    return {31'b0, bus.tdo};
      K_TDO_EN: return {31'b0, bus.tdo_en};
      K_IR:     return {28'b0, bus.ir_value};
      K_USER:   return {24'b0, bus.user_data};
      default:  return {31'b0, bus.abort_pulse};
    endcase
  endfunction

  // Monitor: state expectations are due at their stamped cycle; serial bits whenever tdo_en is up.
  always @(negedge tck) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      check(e.name, observe(e.kind), e.val);
    end
    if (bus.tdo_en === 1'b1) begin
      if (tdo_q.size() == 0) begin
        check("tdo_en_unexpected", {31'b0, bus.tdo_en}, 32'd0);
      end else begin
        e = tdo_q.pop_front();
        check(e.name, {31'b0, bus.tdo}, e.val);
      end
    end
  end

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic drive(input tap_state_e s, input logic d);
    bus.tap_state = s;
    bus.tdi       = d;
  endtask

  task automatic expect_now(input kind_e k, input logic [31:0] v, input string n);
    exp_q.push_back('{cyc, k, v, n});
  endtask

  task automatic shift_bit(input tap_state_e s, input logic d, input logic out, input string n);
    drive(s, d);
    tdo_q.push_back('{cyc, K_TDO, {31'b0, out}, n});
    tick();
  endtask

  task automatic load_ir(input logic [3:0] code, input string tag);
    logic [3:0] cap;
    cap = 4'b0001;
    drive(CAPTURE_IR, 1'b0);
    tick();
    for (int i = 0; i < 4; i++)
      shift_bit(SHIFT_IR, code[i], cap[i], $sformatf("%s_ir_tdo%0d", tag, i));
    drive(UPDATE_IR, 1'b0);
    expect_now(K_ABORT, 32'd0, {tag, "_abort_pre_update"});
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] idc;
    logic [7:0]  ud;
    logic [7:0]  us;
    idc = IDCODE;
    ud  = 8'h3C;
    us  = 8'hA5;

    // Reset with a shift state applied: serial port must stay quiet.
    trst_n          = 1'b0;
    bus.tap_state   = SHIFT_DR;
    bus.tdi         = 1'b1;
    bus.user_status = 8'h00;
    tick();
    expect_now(K_TDO,    32'd0,   "rst_tdo");
    expect_now(K_TDO_EN, 32'd0,   "rst_tdo_en");
    expect_now(K_IR,     32'hE,   "rst_ir_value");
    expect_now(K_USER,   32'd0,   "rst_user_data");
    expect_now(K_ABORT,  32'd0,   "rst_abort");
    tick();
    trst_n = 1'b1;
    drive(RUN_TEST_IDLE, 1'b0);
    tick();

    // IDCODE read, 32 shifts.
    drive(CAPTURE_DR, 1'b0);
    expect_now(K_TDO_EN, 32'd0, "capdr_tdo_en");
    tick();
    for (int i = 0; i < 32; i++)
      shift_bit(SHIFT_DR, 1'b0, idc[i], $sformatf("idcode_b%0d", i));
    drive(RUN_TEST_IDLE, 1'b0);
    expect_now(K_TDO_EN, 32'd0, "idle_tdo_en");
    expect_now(K_TDO,    32'd0, "idle_tdo");
    tick();

    // BYPASS via 1111, then an unassigned code also selects bypass.
    load_ir(4'b1111, "bypass");
    drive(RUN_TEST_IDLE, 1'b0);
    expect_now(K_IR,    32'hF, "bypass_ir_value");
    expect_now(K_ABORT, 32'd0, "bypass_no_abort");
    tick();
    drive(CAPTURE_DR, 1'b0);
    tick();
    shift_bit(SHIFT_DR, 1'b1, 1'b0, "byp_tdo0");
    shift_bit(SHIFT_DR, 1'b0, 1'b1, "byp_tdo1");
    shift_bit(SHIFT_DR, 1'b1, 1'b0, "byp_tdo2");
    load_ir(4'b0011, "unknown");
    drive(RUN_TEST_IDLE, 1'b0);
    expect_now(K_IR, 32'h3, "unknown_ir_value");
    tick();
    drive(CAPTURE_DR, 1'b0);
    tick();
    shift_bit(SHIFT_DR, 1'b1, 1'b0, "unk_byp_tdo0");
    shift_bit(SHIFT_DR, 1'b0, 1'b1, "unk_byp_tdo1");

    // USER: capture A5, shift in 3C, commit.
    load_ir(IR_USER, "user");
    drive(RUN_TEST_IDLE, 1'b0);
    expect_now(K_IR,    32'hA, "user_ir_value");
    expect_now(K_ABORT, 32'd0, "user_no_abort");
    tick();
    bus.user_status = us;
    drive(CAPTURE_DR, 1'b0);
    tick();
    for (int i = 0; i < 8; i++)
      shift_bit(SHIFT_DR, ud[i], us[i], $sformatf("user_b%0d", i));
    drive(UPDATE_DR, 1'b0);
    expect_now(K_USER, 32'd0, "user_data_before_update");
    tick();
    bus.user_status = 8'hFF;
    drive(SELECT_DR_SCAN, 1'b1);
    expect_now(K_USER, 32'h3C, "user_data_after_update");
    tick();
    drive(SELECT_IR_SCAN, 1'b1);
    expect_now(K_USER, 32'h3C, "user_data_hold_seldr");
    expect_now(K_IR,   32'hA,  "ir_hold_seldr");
    tick();

    // ABORT: one-cycle pulse.
    load_ir(IR_ABORT, "abort");
    drive(RUN_TEST_IDLE, 1'b0);
    expect_now(K_ABORT, 32'd1, "abort_pulse_high");
    expect_now(K_IR,    32'h8, "abort_ir_value");
    tick();
    expect_now(K_ABORT, 32'd0, "abort_pulse_low");
    tick();

    // Test-Logic-Reset for one cycle: IDCODE selected, user_data kept.
    drive(TEST_LOGIC_RESET, 1'b1);
    expect_now(K_TDO, 32'd0, "tlr_tdo");
    tick();
    drive(RUN_TEST_IDLE, 1'b0);
    expect_now(K_IR,   32'hE,  "tlr_ir_value");
    expect_now(K_USER, 32'h3C, "tlr_user_data_kept");
    tick();

    // IDCODE scan interrupted by Exit1/Pause/Exit2.
    drive(CAPTURE_DR, 1'b0);
    tick();
    for (int i = 0; i < 10; i++)
      shift_bit(SHIFT_DR, 1'b0, idc[i], $sformatf("pause_idcode_b%0d", i));
    drive(EXIT1_DR, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(PAUSE_DR, 1'b1);
      if (i == 0) expect_now(K_TDO_EN, 32'd0, "pause_tdo_en");
      tick();
    end
    drive(EXIT2_DR, 1'b1);
    tick();
    for (int i = 10; i < 32; i++)
      shift_bit(SHIFT_DR, 1'b0, idc[i], $sformatf("pause_idcode_b%0d", i));

    // Overrun: bit 32 returns the first tdi bit.
    drive(CAPTURE_DR, 1'b0);
    tick();
    for (int i = 0; i < 34; i++)
      shift_bit(SHIFT_DR, (i == 0), (i < 32) ? idc[i] : (i == 32),
                $sformatf("overrun_b%0d", i));

    // trst_n mid USER shift: partial data discarded, no update.
    load_ir(IR_USER, "rst_user");
    drive(RUN_TEST_IDLE, 1'b0);
    tick();
    bus.user_status = us;
    drive(CAPTURE_DR, 1'b0);
    tick();
    for (int i = 0; i < 3; i++)
      shift_bit(SHIFT_DR, 1'b1, us[i], $sformatf("rst_user_b%0d", i));
    drive(SHIFT_DR, 1'b1);
    trst_n = 1'b0;
    expect_now(K_TDO,    32'd0, "midrst_tdo");
    expect_now(K_TDO_EN, 32'd0, "midrst_tdo_en");
    expect_now(K_IR,     32'hE, "midrst_ir_value");
    expect_now(K_USER,   32'd0, "midrst_user_data");
    tick();
    trst_n = 1'b1;
    drive(UPDATE_DR, 1'b1);
    tick();
    drive(RUN_TEST_IDLE, 1'b0);
    expect_now(K_USER, 32'd0, "postrst_user_data");
    expect_now(K_IR,   32'hE, "postrst_ir_value");
    tick();
    // IR shift register must hold its reset value 0001 without a fresh capture.
    shift_bit(SHIFT_IR, 1'b0, 1'b1, "postrst_ir_shift_b0");

    drive(RUN_TEST_IDLE, 1'b0);
    tick();
    tick();
    check("tdo_queue_drained", tdo_q.size(), 32'd0);
    check("exp_queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/jtag_tap_registers.md
JTAG_TAP_REGISTERS -- requirements
Module: jtag_tap_registers

Interface
REQ-001 Parameter IDCODE_VALUE, default 32'h000FAF01, 32-bit value returned by the IDCODE instruction.
REQ-002 Parameter USER_WIDTH, default 8, width of the user data register.
REQ-003 Port: tck, input, 1, the only clock; all state updates on posedge tck.
REQ-004 Port: trst_n, input, 1, reset; asynchronous, active-low.
REQ-005 Port: tap_state, input, 4, current TAP controller state, using the shared 16-state encoding.
REQ-006 Port: tdi, input, 1, serial test data in.
REQ-007 Port: user_status, input, USER_WIDTH, value captured into the user DR in Capture-DR.
REQ-008 Port: tdo, output, 1, serial test data out.
REQ-009 Port: tdo_en, output, 1, high only while tap_state is ShiftDr or ShiftIr.
REQ-010 Port: ir_value, output, 4, currently active instruction.
REQ-011 Port: user_data, output, USER_WIDTH, last value committed in Update-DR under USER.
REQ-012 Port: abort_pulse, output, 1, one-cycle pulse when ABORT is committed in Update-IR.

Function
REQ-013 Instructions SHALL be ABORT=4'b1000, USER=4'b1010, IDCODE=4'b1110, BYPASS=4'b1111; any other code SHALL select the bypass register.
REQ-014 The IR shift register (4 bits) SHALL load 4'b0001 on the edge where tap_state==CaptureIr.
REQ-015 In ShiftIr, each edge SHALL shift the IR shift register right, with tdi entering bit 3.
REQ-016 On the edge where tap_state==UpdateIr, ir_value SHALL take the IR shift register contents.
REQ-017 On the edge where tap_state==UpdateIr with shift contents ABORT, abort_pulse SHALL be 1 for exactly the following cycle.
REQ-018 On any edge with tap_state==TestLogicReset, ir_value SHALL become IDCODE; the shift registers SHALL remain unchanged.
REQ-019 Capture-DR loading, per selected register:
- IDCODE: load a 32-bit shift register with IDCODE_VALUE.
- BYPASS: load the bypass bit with 0.
- USER: load the user shift register with user_status.
REQ-020 In ShiftDr, only the selected DR SHALL shift right, with tdi entering its MSB; unselected DRs SHALL hold.
REQ-021 On the edge where tap_state==UpdateDr with ir_value==USER, user_data SHALL take the user shift register; otherwise user_data SHALL hold.
REQ-022 tdo SHALL be combinational:
- ShiftIr: IR shift register bit 0.
- ShiftDr: bit 0 of the selected DR.
- Otherwise: 0.
The first bit after Capture is therefore visible with zero latency.
REQ-023 Pause, Exit1 and Exit2 states SHALL hold all shift registers, so a scan resumes without bit loss.
REQ-024 Shifting beyond a register's length SHALL return the tdi bits shifted in (for example, bit 32 of IDCODE equals the first tdi bit); no wrap or saturation.
REQ-025 No change SHALL occur in any other TAP state, including RunTestOrIdle, SelectDrScan and SelectIrScan.

Reset
REQ-026 While trst_n==0, asynchronously:
- ir_value=IDCODE, IR shift=4'b0001.
- IDCODE shift=0, bypass=0, user shift=0, user_data=0.
- abort_pulse=0.
REQ-027 tdo and tdo_en SHALL be 0 during reset regardless of tap_state.
REQ-028 Reset asserted mid-scan SHALL discard partial shift data; no Update SHALL occur.

Structure
REQ-029 A shared package SHALL hold the 4-bit TAP state encoding (TestLogicReset=0 through UpdateIr=15) and the instruction code constants, also used by the TAP controller.
REQ-030 One sub-module jtag_shift_reg (parameterised width; capture, shift and hold controls; serial in/out) SHALL implement the IR, IDCODE and user registers.

Verification
REQ-031 After reset, CaptureDr then 32×ShiftDr with tdi=0: tdo sequence is LSB-first 0x000FAF01; tdo_en=1 only during those 32 cycles.
REQ-032 CaptureIr, then ShiftIr with tdi=1,1,1,1, then UpdateIr: tdo outputs 1,0,0,0 and ir_value=4'b1111; a following CaptureDr plus 3 ShiftDr with tdi=1,0,1 gives tdo=0,1,0.
REQ-033 IR=USER, user_status=8'hA5: Capture, 8 shifts with tdi bits of 0x3C, UpdateDr: tdo emits 0xA5 LSB-first and user_data=8'h3C.
REQ-034 Shift IR=4'b1000 then UpdateIr: abort_pulse is high for exactly one cycle; ir_value=4'b1000.
REQ-035 IDCODE scan with ShiftDr×10, Exit1Dr, PauseDr×5, Exit2Dr, ShiftDr×22: the concatenated tdo bits equal 0x000FAF01.
REQ-036 trst_n pulsed low mid-USER shift, or tap_state=TestLogicReset for one cycle: ir_value=IDCODE, user_data unchanged by the TestLogicReset case, and tdo=0.
